// File: rtl/fft_twiddle_sequencer.sv
// Butterfly command sequencer for a 64-point radix-2 DIT FFT.
// Walks 6 stages x 32 butterflies and drives the sin/cos twiddle ROM selects.
module fft_twiddle_sequencer #(
   parameter int unsigned STAGE_GAP = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       bf_ready,
   output logic       bf_valid,
   output logic [2:0] stage,
   output logic [4:0] bfly,
   output logic [5:0] addr_a,
   output logic [5:0] addr_b,
   output logic [5:0] tw_im_sel,
   output logic [5:0] tw_re_sel,
   output logic       last,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

   localparam bit         HasGap  = (STAGE_GAP > 0);
   localparam logic [3:0] GapLoad = HasGap ? 4'(STAGE_GAP - 1) : 4'd0;

   state_e     state_q;
   logic [2:0] stage_q;
   logic [4:0] bfly_q;
   logic [3:0] gap_q;
   logic       valid_q;
   logic       busy_q;
   logic       done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         stage_q <= 3'd0;
         bfly_q  <= 5'd0;
         gap_q   <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (abort) begin
         state_q <= StIdle;
         stage_q <= 3'd0;
         bfly_q  <= 5'd0;
         gap_q   <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  stage_q <= 3'd0;
                  bfly_q  <= 5'd0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               if (bf_ready) begin
                  bfly_q <= bfly_q + 5'd1;
                  if (bfly_q == 5'd31) begin
                     if (stage_q == 3'd5) begin
                        state_q <= StDone;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                     end else if (HasGap) begin
                        // stage advances on leaving the gap
                        state_q <= StGap;
                        gap_q   <= GapLoad;
                        valid_q <= 1'b0;
                     end else begin
                        stage_q <= stage_q + 3'd1;
                     end
                  end
               end
            end
            StGap: begin
               if (gap_q == 4'd0) begin
                  state_q <= StRun;
                  stage_q <= stage_q + 3'd1;
                  valid_q <= 1'b1;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               stage_q <= 3'd0;
               bfly_q  <= 5'd0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   logic [5:0] half;
   logic [4:0] pos;
   logic [4:0] grp;
   logic [5:0] k;

   // Pair spacing doubles each stage; bit s of addr_a is always 0 so addr_b never wraps.
   always_comb begin
      half   = 6'd1 << stage_q;
      pos    = bfly_q & 5'(half - 6'd1);
      grp    = bfly_q >> stage_q;
      addr_a = ({1'b0, grp} << (stage_q + 3'd1)) | {1'b0, pos};
      addr_b = addr_a + half;
      k      = {1'b0, pos} << (3'd5 - stage_q);
   end

   // cos(x) = -sin(x - pi/2), so the real part reads the same ROM shifted by 48
   assign tw_im_sel = k;
   assign tw_re_sel = k + 6'd48;

   assign bf_valid = valid_q;
   assign stage    = stage_q;
   assign bfly     = bfly_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign last     = valid_q && (stage_q == 3'd5) && (bfly_q == 5'd31);

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: one instance with the default gap,
// one with no gap, exercised together from shared stimulus.
module tb_fft_twiddle_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, bf_ready;
   logic       v, last, busy, done;
   logic [2:0] st;
   logic [4:0] bf;
   logic [5:0] aa, ab, im, re;
   logic       vz, lastz, busyz, donez;
   logic [2:0] stz;
   logic [4:0] bfz;
   logic [5:0] aaz, abz, imz, rez;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int   cyc;
      logic valid;
      int   s, b, a, bb, im, re, rom_re, rom_im;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   fft_twiddle_sequencer #(.STAGE_GAP(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bf_ready(bf_ready),
      .bf_valid(v), .stage(st), .bfly(bf), .addr_a(aa), .addr_b(ab),
      .tw_im_sel(im), .tw_re_sel(re), .last(last), .busy(busy), .done(done)
   );

   fft_twiddle_sequencer #(.STAGE_GAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bf_ready(bf_ready),
      .bf_valid(vz), .stage(stz), .bfly(bfz), .addr_a(aaz), .addr_b(abz),
      .tw_im_sel(imz), .tw_re_sel(rez), .last(lastz), .busy(busyz), .done(donez)
   );

   logic [31:0] cmd_act, cmd_z;
   assign cmd_act = {st, bf, aa, ab, im, re};
   assign cmd_z   = {stz, bfz, aaz, abz, imz, rez};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int rom(input int i);
      real x;
      x = -256.0 * $sin(2.0 * 3.141592653589793 * i / 64.0);
      if (x < 0.0) return $rtoi(x - 0.5);
      return $rtoi(x + 0.5);
   endfunction

   // Pairing model: groups of 2*span words, legs span apart, twiddle stride 32/span.
   function automatic logic [31:0] cmd_exp(input int s, input int b);
      int span, a, k;
      span = 1 << s;
      a    = (b / span) * 2 * span + b % span;
      k    = (b % span) * (32 / span);
      return {3'(s), 5'(b), 6'(a), 6'(a + span), 6'(k), 6'((k + 48) % 64)};
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_ctl"}, {28'd0, v, busy, done, last}, 32'd0);
      check({tag, "_cmd"}, cmd_act, {3'd0, 5'd0, 6'd0, 6'd1, 6'd0, 6'd48});
      check({tag, "_busy0"}, {31'd0, busyz}, 32'd0);
   endtask

   task automatic full_run(input string tag);
      @(negedge clk);
      start    = 1'b1;
      bf_ready = 1'b1;
      for (int cyc = 1; cyc <= 215; cyc++) begin
         int t, j, r;
         logic ev, evz;
         @(negedge clk);
         start = 1'b0;
         t  = cyc - 1;
         j  = t / 36;
         r  = t % 36;
         ev = (j < 6) && (r < 32);
         check({tag, "_ctl"}, {28'd0, v, busy, done, last},
               {28'd0, ev, cyc <= 213, cyc == 213, cyc == 212});
         if (ev) check({tag, "_cmd"}, cmd_act, cmd_exp(j, r));
         evz = (cyc <= 192);
         check({tag, "_ctl_nogap"}, {28'd0, vz, busyz, donez, lastz},
               {28'd0, evz, cyc <= 193, cyc == 193, cyc == 192});
         if (evz) check({tag, "_cmd_nogap"}, cmd_z, cmd_exp(t / 32, t % 32));
         foreach (vecs[i]) begin
            if (vecs[i].cyc == cyc) begin
               check({tag, "_vec_valid"}, {31'd0, v}, {31'd0, vecs[i].valid});
               if (vecs[i].valid) begin
                  check({tag, "_vec_cmd"}, cmd_act,
                        {3'(vecs[i].s), 5'(vecs[i].b), 6'(vecs[i].a), 6'(vecs[i].bb),
                         6'(vecs[i].im), 6'(vecs[i].re)});
                  check({tag, "_vec_rom_re"}, rom(int'(re)), vecs[i].rom_re);
                  check({tag, "_vec_rom_im"}, rom(int'(im)), vecs[i].rom_im);
               end
            end
         end
      end
   endtask

   task automatic backpressure();
      logic [31:0] held;
      logic stalled;
      int n;
      bit done_seen;
      bit seen[6][64];
      foreach (seen[i, j]) seen[i][j] = 1'b0;
      held = '0;
      stalled = 1'b0;
      n = 0;
      done_seen = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      bf_ready = 1'($urandom_range(0, 1));
      for (int cyc = 1; cyc <= 2000 && !done_seen; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (stalled) begin
            check("bp_hold_cmd", cmd_act, held);
            check("bp_hold_valid", {31'd0, v}, 32'd1);
         end
         if (done) done_seen = 1'b1;
         bf_ready = 1'($urandom_range(0, 1));
         if (v && bf_ready) begin
            check("bp_seq", cmd_act, cmd_exp(n / 32, n % 32));
            if (st < 3'd6) begin
               check("bp_uniq", {30'd0, seen[st][aa], seen[st][ab]}, 32'd0);
               seen[st][aa] = 1'b1;
               seen[st][ab] = 1'b1;
            end
            n++;
         end
         stalled = v && !bf_ready;
         held    = cmd_act;
      end
      check("bp_beats", n, 192);
      check("bp_done_seen", {31'd0, done_seen}, 32'd1);
      bf_ready = 1'b1;
      @(negedge clk);
      check("bp_busy_fall", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 200 && busyz; i++) @(negedge clk);
   endtask

   task automatic abort_test();
      int dc;
      @(negedge clk);
      start    = 1'b1;
      bf_ready = 1'b1;
      for (int cyc = 1; cyc <= 83; cyc++) begin
         int t, j, r;
         logic ev;
         @(negedge clk);
         start = (cyc == 6);
         t  = cyc - 1;
         j  = t / 36;
         r  = t % 36;
         ev = (j < 6) && (r < 32);
         check("ab_valid", {31'd0, v}, {31'd0, ev});
         if (ev) check("ab_cmd", cmd_act, cmd_exp(j, r));
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("ab_idle", {20'd0, v, busy, done, st, bf}, 32'd0);
      dc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) dc++;
      end
      check("ab_no_done", dc, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ab_restart_valid", {31'd0, v}, 32'd1);
      check("ab_restart_cmd", cmd_act, cmd_exp(0, 0));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("ab_start_with_abort", {30'd0, busy, v}, 32'd0);
   endtask

   task automatic reset_mid_run();
      bit found;
      found = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      bf_ready = 1'b1;
      for (int cyc = 1; cyc <= 300 && !found; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (st == 3'd3 && !v && busy) found = 1'b1;
      end
      check("rst_reached_gap3", {31'd0, found}, 32'd1);
      #1 rst_n = 1'b0;
      #1 check_reset_values("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      full_run("rerun");
   endtask

   initial begin
      vecs[0] = '{8,   1'b1, 0, 7,  14, 15, 0,  48, 256,  0};
      vecs[1] = '{33,  1'b0, 0, 0,  0,  0,  0,  0,  0,    0};
      vecs[2] = '{37,  1'b1, 1, 0,  0,  2,  0,  48, 256,  0};
      vecs[3] = '{114, 1'b1, 3, 5,  5,  13, 20, 4,  -98,  -237};
      vecs[4] = '{181, 1'b1, 5, 0,  0,  32, 0,  48, 256,  0};
      vecs[5] = '{212, 1'b1, 5, 31, 31, 63, 31, 15, -255, -25};

      rst_n    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      bf_ready = 1'b1;
      #3 rst_n = 1'b0;
      #1 check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      full_run("run");
      backpressure();
      abort_test();
      reset_mid_run();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_twiddle_sequencer.md
# fft_twiddle_sequencer

Control sequencer for the 64-point radix-2 decimation-in-time FFT. It walks all 6 stages × 32 butterflies and emits one butterfly command per beat on a valid/ready interface: a pair of in-place data addresses and the twiddle index `k`. It also drives the `select` inputs of two 64-entry twiddle ROMs. Each ROM holds `T[i] = round(-256·sin(2πi/64))`, 10-bit signed Q8. One ROM gives the imaginary part, the other the real part, of `W^k = e^(-j2πk/64)`.

## Interface

Parameters:
- `STAGE_GAP`, default 4: idle cycles inserted between stages so the butterfly pipeline can drain and write back. Legal range 0–15.

Ports:
- `clk` — input, 1 — sole clock; everything is rising-edge.
- `rst_n` — input, 1 — reset, asynchronous, active-low.
- `start` — input, 1 — pulse; begins a transform when in IDLE.
- `abort` — input, 1 — synchronous; returns to IDLE on the next edge.
- `bf_ready` — input, 1 — butterfly unit accepts the current command.
- `bf_valid` — output, 1 — command fields below are valid.
- `stage` — output, 3 — current stage, 0–5.
- `bfly` — output, 5 — butterfly index within the stage, 0–31.
- `addr_a` — output, 6 — upper-leg data address.
- `addr_b` — output, 6 — lower-leg data address.
- `tw_im_sel` — output, 6 — ROM select for Im(W^k); equals `k`.
- `tw_re_sel` — output, 6 — ROM select for Re(W^k); equals `(k+48) mod 64`.
- `last` — output, 1 — current beat is stage 5, bfly 31.
- `busy` — output, 1 — high in every state except IDLE.
- `done` — output, 1 — one-cycle pulse at end of transform.

## Operation

States: IDLE, RUN, GAP, DONE.
- IDLE → RUN on `start`; `stage` and `bfly` are cleared.
- RUN: `bf_valid` = 1. A beat is accepted when `bf_valid && bf_ready`; each accepted beat increments `bfly`.
- Accepted beat with `bfly` = 31:
  - `stage` < 5 and `STAGE_GAP` > 0: go to GAP with gap counter = `STAGE_GAP`-1, then `stage`++ and `bfly` = 0.
  - `stage` < 5 and `STAGE_GAP` = 0: stay in RUN, `stage`++, `bfly` = 0.
  - `stage` = 5: go to DONE.
- GAP: `bf_valid` = 0. Counter decrements each cycle; at 0, go to RUN.
- DONE: `done` = 1 for exactly one cycle, then IDLE.

Address and twiddle arithmetic, combinational from the `stage`/`bfly` registers, with s = `stage`, b = `bfly`:
- half = 1<<s; pos = b & (half-1); grp = b >> s.
- `addr_a` = (grp<<(s+1)) | pos.
- `addr_b` = `addr_a` + half.
- k = pos << (5-s), always in 0–31.
- `tw_re_sel` = k + 48, truncated to 6 bits; this works because `T[(k-16) mod 64] = 256·cos(2πk/64)`.

Rules:
- While `bf_valid` = 1 and `bf_ready` = 0, all command outputs hold stable.
- `start` is ignored unless in IDLE.
- `abort` has priority over every other transition, in any state. The next edge gives IDLE with `stage`/`bfly` = 0 and no `done` pulse.
- If `abort` and `start` are high together in IDLE, the block stays in IDLE.
- `last` = RUN && `stage` = 5 && `bfly` = 31.

## Timing

- Reset values: IDLE, `bf_valid`/`busy`/`done`/`last` = 0, `stage` = 0, `bfly` = 0. This gives `addr_a` = 0, `addr_b` = 1, `tw_im_sel` = 0, `tw_re_sel` = 48.
- `rst_n` asserted mid-run clears the block immediately and asynchronously to the reset values.
- `start` sampled at edge N gives `bf_valid` = 1 from cycle N+1; the first command is visible in that same cycle.
- Throughput is one beat per cycle while `bf_ready` = 1.
- Total transform with `bf_ready` tied high is 192 + 5·`STAGE_GAP` cycles of RUN/GAP, followed by DONE.
- `busy` falls in the cycle after `done`.
- ROM outputs are combinational from the selects. Consumers sample `addr`, `k` and ROM data on the accepting edge.

## Test plan

- **Full run, default gap:** `STAGE_GAP`=4, `bf_ready`=1, `start` at cycle 0.
  - Beats occur in cycles 1–32, 37–68, … 181–212.
  - `done`=1 at cycle 213 only; 192 accepted beats total.
  - `last` is high only at cycle 212.
- **Arithmetic spot checks:**
  - s=3, b=5 → `addr_a`=5, `addr_b`=13, k=20, `tw_re_sel`=4. The ROMs must return re=-98, im=-237.
  - s=5, b=31 → `addr_a`=31, `addr_b`=63, `tw_im_sel`=31, `tw_re_sel`=15.
  - s=0, b=7 → `addr_a`=14, `addr_b`=15, k=0, `tw_re_sel`=48.
- **Backpressure:** random `bf_ready` (≈50%) → outputs stable while stalled. The sequence of accepted (`stage`, `bfly`) pairs equals the no-stall sequence, and every (`addr_a`, `addr_b`) pair is unique within its stage.
- **`STAGE_GAP`=0:** stage 0, bfly 31 is accepted at cycle 32 → stage 1, bfly 0 is valid at cycle 33. `done` at cycle 193.
- **Abort and ignored start:**
  - `start` re-pulsed during RUN → no effect on the sequence.
  - `abort` at stage 2, bfly 10 → IDLE next cycle, `busy`=0, no `done` pulse.
  - A new `start` afterwards → restarts at stage 0, bfly 0.
- **Async reset mid-run:** `rst_n` low during GAP of stage 3, asserted between clock edges → all outputs take reset values before the next edge. Release and `start` → a complete, correct transform.
